// File: rtl/ext_bus_pkg.sv
// Shared widths, CTRL register index and arbiter state encoding for the
// external-bus memory slave.
package ext_bus_pkg;

  localparam int BUS_ADDR_W = 18;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = 4;
  localparam int WORD_IDX_W = BUS_ADDR_W - 2;

  localparam logic [WORD_IDX_W-1:0] CTRL_IDX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_ACCESS,
    ST_RESP
  } bus_state_t;

endpackage

// File: rtl/ext_bus_mem_slave_if.sv
// One HPS external-bus bridge conduit; the bridge is master, the memory slave answers.
interface ext_bus_mem_slave_if;
  import ext_bus_pkg::*;

  logic [BUS_ADDR_W-1:0] bus_address;
  logic                  bus_bus_enable;
  logic [BUS_BE_W-1:0]   bus_byte_enable;
  logic                  bus_rw;
  logic [BUS_DATA_W-1:0] bus_write_data;
  logic [BUS_DATA_W-1:0] bus_read_data;
  logic                  bus_acknowledge;
  logic                  bus_irq;

  modport master (
    output bus_address, bus_bus_enable, bus_byte_enable, bus_rw, bus_write_data,
    input  bus_read_data, bus_acknowledge, bus_irq
  );

  modport slave (
    input  bus_address, bus_bus_enable, bus_byte_enable, bus_rw, bus_write_data,
    output bus_read_data, bus_acknowledge, bus_irq
  );

endinterface

// File: rtl/bytewise_sp_ram.sv
// Single-port synchronous RAM with per-byte write enables.
// Latency: read data one cycle after the address. Backpressure: none, one access per cycle.
// Read-before-write: a same-cycle write returns the old word.
module bytewise_sp_ram #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] we,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_W/8; b++) begin
      if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ext_bus_mem_slave.sv
// Bus-side RAM slave sharing one RAM port with a priority soft-core port, plus done-irq latch.
// Latency: bus acknowledge 3 cycles after enable, +1 per lost arbitration; core read data next cycle.
// Backpressure: core_stall while the bus owns the RAM; bus forced through after STALL_LIMIT losses.
module ext_bus_mem_slave
  import ext_bus_pkg::*;
#(
  parameter int                    ADDR_W      = 14,
  parameter int                    STALL_LIMIT = 8,
  parameter logic [BUS_DATA_W-1:0] OOR_RDATA   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  ext_bus_mem_slave_if.slave    bus,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_W-1:0]     core_addr,
  input  logic [BUS_BE_W-1:0]   core_be,
  input  logic [BUS_DATA_W-1:0] core_wdata,
  output logic                  core_stall,
  output logic [BUS_DATA_W-1:0] core_rdata,
  output logic                  core_rvalid,
  input  logic                  core_done
);

  localparam int CNT_W = $clog2(STALL_LIMIT + 1);

  bus_state_t            state;
  logic [CNT_W-1:0]      stall_cnt;
  logic                  irq_pending;
  logic [WORD_IDX_W-1:0] cap_idx;
  logic [BUS_BE_W-1:0]   cap_be;
  logic                  cap_rw;
  logic [BUS_DATA_W-1:0] cap_wdata;
  logic [BUS_DATA_W-1:0] resp_dat;
  logic                  resp_from_ram;
  logic                  core_rvalid_q;

  logic                  at_limit, grant, bus_owns, core_go;
  logic                  cap_in_range, cap_is_ctrl, ctrl_clear;
  logic [ADDR_W-1:0]     ram_addr;
  logic [BUS_BE_W-1:0]   ram_we;
  logic [BUS_DATA_W-1:0] ram_wdata, ram_rdata;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^bus.bus_address[1:0];

  assign cap_in_range = (cap_idx >> ADDR_W) == '0;
  assign cap_is_ctrl  = (cap_idx == CTRL_IDX);
  assign at_limit     = (stall_cnt == CNT_W'(STALL_LIMIT));
  assign grant        = (state == ST_ARB) && (!core_req || at_limit);
  assign bus_owns     = (state == ST_ACCESS);
  assign core_stall   = core_req && (bus_owns || ((state == ST_ARB) && at_limit));
  assign core_go      = core_req && !core_stall;
  assign ctrl_clear   = bus_owns && cap_is_ctrl && !cap_rw && cap_be[0] && cap_wdata[0];

  // The single RAM port belongs to the bus only during ACCESS.
  assign ram_addr  = bus_owns ? cap_idx[ADDR_W-1:0] : core_addr;
  assign ram_wdata = bus_owns ? cap_wdata : core_wdata;
  assign ram_we    = bus_owns ? (cap_be & {BUS_BE_W{!cap_rw && cap_in_range}})
                              : (core_be & {BUS_BE_W{core_go && core_we}});

  bytewise_sp_ram #(.ADDR_W(ADDR_W), .DATA_W(BUS_DATA_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.bus_bus_enable) begin
      cap_idx   <= bus.bus_address[BUS_ADDR_W-1:2];
      cap_be    <= bus.bus_byte_enable;
      cap_rw    <= bus.bus_rw;
      cap_wdata <= bus.bus_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      stall_cnt     <= '0;
      irq_pending   <= 1'b0;
      resp_dat      <= '0;
      resp_from_ram <= 1'b0;
      core_rvalid_q <= 1'b0;
    end else begin
      core_rvalid_q <= core_go && !core_we;
      if (core_done)       irq_pending <= 1'b1;
      else if (ctrl_clear) irq_pending <= 1'b0;

      unique case (state)
        ST_IDLE: if (bus.bus_bus_enable) state <= ST_ARB;
        ST_ARB: begin
          if (grant) begin
            state     <= ST_ACCESS;
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + CNT_W'(1);
          end
        end
        ST_ACCESS: begin
          state         <= ST_RESP;
          resp_from_ram <= cap_rw && cap_in_range;
          resp_dat      <= !cap_rw     ? '0 :
                           cap_is_ctrl ? {{(BUS_DATA_W-1){1'b0}}, irq_pending} :
                                         OOR_RDATA;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM read data arrives straight out of the RAM register during RESP.
  assign bus.bus_acknowledge = (state == ST_RESP);
  assign bus.bus_read_data   = (state == ST_RESP) ? (resp_from_ram ? ram_rdata : resp_dat) : '0;
  assign bus.bus_irq         = irq_pending;
  assign core_rvalid         = core_rvalid_q;
  assign core_rdata          = core_rvalid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_ext_bus_mem_slave.sv
// Directed bench for ext_bus_mem_slave: bus access timing, byte lanes, arbitration, irq, range, reset.
module tb_ext_bus_mem_slave;
  import ext_bus_pkg::*;

  localparam int          ADDR_W = 14;
  localparam logic [31:0] OOR    = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              reset;
  logic              core_req, core_we, core_done;
  logic [ADDR_W-1:0] core_addr;
  logic [3:0]        core_be;
  logic [31:0]       core_wdata, core_rdata;
  logic              core_stall, core_rvalid;

  int n_cmp = 0;
  int n_bad = 0;

  ext_bus_mem_slave_if bif ();

  ext_bus_mem_slave #(.ADDR_W(ADDR_W), .STALL_LIMIT(8), .OOR_RDATA(OOR)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bif.slave),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_be     (core_be),
    .core_wdata  (core_wdata),
    .core_stall  (core_stall),
    .core_rdata  (core_rdata),
    .core_rvalid (core_rvalid),
    .core_done   (core_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bus(input logic rw, input logic [17:0] addr, input logic [3:0] be,
                           input logic [31:0] wd);
    bif.bus_address     = addr;
    bif.bus_rw          = rw;
    bif.bus_byte_enable = be;
    bif.bus_write_data  = wd;
    bif.bus_bus_enable  = 1'b1;
  endtask

  // Returns read data seen in the acknowledge cycle and enable-to-acknowledge cycle count.
  task automatic bus_txn(input logic rw, input logic [17:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, output logic [31:0] rd, output int lat);
    drive_bus(rw, addr, be, wd);
    step();
    bif.bus_bus_enable = 1'b0;
    lat = 1;
    while (!bif.bus_acknowledge && lat < 40) begin
      step();
      lat++;
    end
    rd = bif.bus_read_data;
    step();
  endtask

  logic [31:0] rd;
  int          lat, acks;
  logic [10:0] stall_v, ack_v;
  logic [31:0] ack_dat;

  initial begin
    reset = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_done = 1'b0;
    core_addr = '0; core_be = '0; core_wdata = '0;
    bif.bus_address = '0; bif.bus_bus_enable = 1'b0; bif.bus_byte_enable = '0;
    bif.bus_rw = 1'b0; bif.bus_write_data = '0;
    repeat (3) step();
    check("rst_ack",    32'(bif.bus_acknowledge), 32'd0);
    check("rst_rdata",  bif.bus_read_data,        32'd0);
    check("rst_irq",    32'(bif.bus_irq),         32'd0);
    check("rst_stall",  32'(core_stall),          32'd0);
    check("rst_rvalid", 32'(core_rvalid),         32'd0);
    check("rst_crdata", core_rdata,               32'd0);
    reset = 1'b0;
    step();

    bus_txn(1'b0, 18'h00010, 4'hF, 32'hCAFE_F00D, rd, lat);
    check("wr_lat",   32'(lat), 32'd3);
    check("wr_rdata", rd,       32'd0);
    bus_txn(1'b1, 18'h00010, 4'hF, 32'h0, rd, lat);
    check("rd_lat",   32'(lat), 32'd3);
    check("rd_data",  rd,       32'hCAFE_F00D);

    bus_txn(1'b0, 18'h00020, 4'hF,    32'h1122_3344, rd, lat);
    bus_txn(1'b0, 18'h00020, 4'b0101, 32'hAABB_CCDD, rd, lat);
    bus_txn(1'b1, 18'h00020, 4'hF,    32'h0,         rd, lat);
    check("byte_lanes", rd, 32'h11BB_33DD);

    // Contention: core reads word 5 every cycle while the bus reads 0x10.
    bus_txn(1'b0, 18'h00014, 4'hF, 32'h55AA_0005, rd, lat);
    core_req = 1'b1; core_we = 1'b0; core_addr = 14'd5; core_be = 4'hF;
    drive_bus(1'b1, 18'h00010, 4'hF, 32'h0);
    step();
    bif.bus_bus_enable = 1'b0;
    ack_dat = '0;
    for (int i = 0; i < 11; i++) begin
      stall_v[i] = core_stall;
      ack_v[i]   = bif.bus_acknowledge;
      if (bif.bus_acknowledge) ack_dat = bif.bus_read_data;
      if (i < 10) step();
    end
    check("cont_stall_pattern", 32'(stall_v), 32'h0000_0300);
    check("cont_ack_cycle",     32'(ack_v),   32'h0000_0400);
    check("cont_rdata",         ack_dat,      32'hCAFE_F00D);
    step();
    check("cont_core_resume_stall",  32'(core_stall),  32'd0);
    check("cont_core_resume_rvalid", 32'(core_rvalid), 32'd1);
    check("cont_core_resume_rdata",  core_rdata,       32'h55AA_0005);
    core_req = 1'b0;
    step();

    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("irq_set", 32'(bif.bus_irq), 32'd1);
    bus_txn(1'b1, 18'h3FFFC, 4'hF, 32'h0, rd, lat);
    check("ctrl_read", rd, 32'd1);
    bus_txn(1'b0, 18'h3FFFC, 4'h1, 32'h1, rd, lat);
    check("irq_clear", 32'(bif.bus_irq), 32'd0);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    // Clear write whose ACCESS cycle coincides with core_done.
    drive_bus(1'b0, 18'h3FFFC, 4'h1, 32'h1);
    step();
    bif.bus_bus_enable = 1'b0;
    step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("irq_race_ack", 32'(bif.bus_acknowledge), 32'd1);
    step();
    check("irq_set_wins", 32'(bif.bus_irq), 32'd1);

    bus_txn(1'b1, 18'h10000, 4'hF, 32'h0, rd, lat);
    check("oor_rd_lat",  32'(lat), 32'd3);
    check("oor_rd_data", rd,       OOR);
    bus_txn(1'b0, 18'h00000, 4'hF, 32'h1234_5678, rd, lat);
    bus_txn(1'b0, 18'h10000, 4'hF, 32'hFFFF_FFFF, rd, lat);
    check("oor_wr_lat",  32'(lat), 32'd3);
    bus_txn(1'b1, 18'h00000, 4'hF, 32'h0, rd, lat);
    check("oor_wr_dropped", rd, 32'h1234_5678);

    drive_bus(1'b1, 18'h00010, 4'hF, 32'h0);
    step();
    step();
    bif.bus_bus_enable = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (bif.bus_acknowledge) acks++;
      step();
    end
    check("double_enable_acks", 32'(acks), 32'd1);

    // irq is still pending here; reset must clear it and abort the write.
    drive_bus(1'b0, 18'h00000, 4'hF, 32'hAAAA_AAAA);
    step();
    bif.bus_bus_enable = 1'b0;
    reset = 1'b1;
    step();
    check("rst_mid_ack",    32'(bif.bus_acknowledge), 32'd0);
    check("rst_mid_rdata",  bif.bus_read_data,        32'd0);
    check("rst_mid_irq",    32'(bif.bus_irq),         32'd0);
    check("rst_mid_stall",  32'(core_stall),          32'd0);
    check("rst_mid_rvalid", 32'(core_rvalid),         32'd0);
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bif.bus_acknowledge) acks++;
    end
    check("rst_mid_no_ack", 32'(acks), 32'd0);
    bus_txn(1'b1, 18'h00000, 4'hF, 32'h0, rd, lat);
    check("rst_mid_write_discarded", rd, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ext_bus_mem_slave.md
Name: ext_bus_mem_slave

Overview:
- Downstream consumer of one HPS external-bus bridge conduit (dm_bus / im_bus / rf_bus): 18-bit byte address, 32-bit data, byte enables, rw, acknowledge, irq.
- Owns a word-wide single-port synchronous RAM. The host loads and inspects it over the bus while the soft core uses a second, priority port.
- Arbitrates between the two ports and raises a latched irq on a core "done" event.
- Instantiated once per memory-type bus.

Parameters:
- ADDR_W, 14, RAM word-address width (depth 2^ADDR_W words, 64 KiB default)
- STALL_LIMIT, 8, consecutive cycles the bus may lose arbitration before it is forced a grant
- OOR_RDATA, 32'h0000_0000, read data returned for out-of-range addresses

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- bus_address  in  18  byte address; [1:0] ignored
- bus_bus_enable  in  1  one-cycle transaction request pulse
- bus_byte_enable  in  4  write byte lanes
- bus_rw  in  1  1=read, 0=write
- bus_write_data  in  32  write data
- bus_read_data  out  32  read data, valid only in the acknowledge cycle
- bus_acknowledge  out  1  one-cycle completion pulse
- bus_irq  out  1  level, done-pending flag
- core_req  in  1  core RAM access request
- core_we  in  1  core write
- core_addr  in  ADDR_W  core word address
- core_be  in  4  core byte enables
- core_wdata  in  32  core write data
- core_stall  out  1  core request not served this cycle
- core_rdata  out  32  core read data
- core_rvalid  out  1  core read data valid, one cycle after a granted read
- core_done  in  1  pulse that sets irq pending

Behaviour:
- Reset values: bus_acknowledge=0, bus_read_data=0, bus_irq=0, core_stall=0, core_rvalid=0, core_rdata=0; FSM=IDLE; stall counter=0. RAM contents are not reset.
- Word index is bus_address[17:2]. In range when index < 2^ADDR_W. Index 16'hFFFF is CTRL; it must lie outside the RAM range, so ADDR_W <= 15.
- CTRL read returns {31'b0, irq_pending}. CTRL write with byte_enable[0]=1 and write_data[0]=1 clears irq_pending.
- Other out-of-range accesses: reads return OOR_RDATA, writes are dropped. Both are still acknowledged.
- irq_pending is set by core_done. Set has priority over a same-cycle clear. bus_irq = irq_pending (registered).
- FSM states:
  - IDLE: on bus_bus_enable, capture address/be/rw/wdata and go to ARB.
  - ARB: the bus is granted when core_req=0 or stall_cnt==STALL_LIMIT; on grant go to ACCESS. Otherwise stall_cnt++ and remain in ARB.
  - ACCESS: RAM or CTRL is accessed this cycle; go to RESP.
  - RESP: bus_acknowledge=1 for one cycle with bus_read_data; return to IDLE.
- Minimum latency: enable at cycle T, ARB at T+1, ACCESS at T+2, acknowledge at T+3. Each lost arbitration cycle adds one cycle. Write acknowledges use the same timing; bus_read_data=0 on writes.
- In ACCESS the RAM belongs to the bus: core_stall=1 and the core request is not performed.
- In ARB with a forced grant: core_stall=1 in that cycle.
- Otherwise the core is served every cycle with core_stall=0. RAM read latency is 1 cycle, so core_rvalid is asserted the next cycle with core_rdata.
- stall_cnt clears on every bus grant.
- Byte-enable writes update only the enabled lanes. be=0 writes nothing but is still acknowledged.
- bus_bus_enable while not IDLE is ignored: no capture, no second acknowledge.
- Reset mid-transaction aborts it: no acknowledge is issued and any pending RAM write in ARB is discarded. A write already in ACCESS completes, since the RAM write is in the same edge.

Decomposition:
- Shared package ext_bus_pkg holds:
  - the bus field widths (BUS_ADDR_W=18, BUS_DATA_W=32, BUS_BE_W=4);
  - the CTRL word index constant;
  - the FSM state enum.
- One sub-module, bytewise_sp_ram: single-port RAM with a 1-cycle read, per-byte write enables, and ADDR_W/32-bit parameters. The arbiter/FSM lives in the top.

Test Plan:
- Idle core: bus write 0x0000_0010 data 0xCAFEF00D be=4'hF, then read the same address. Acknowledge arrives exactly 3 cycles after each enable; read_data=0xCAFEF00D.
- Byte lanes: write 0x11223344 be=4'hF, then write 0xAABBCCDD be=4'b0101; read returns 0x11BB33DD.
- Contention: core_req held high continuously, bus read issued. core_stall=0 for 8 cycles; forced grant on the 9th ARB cycle with core_stall=1; acknowledge at T+11; the core resumes afterwards.
- IRQ: pulse core_done → bus_irq=1 next cycle. Read CTRL (address 0x3FFFC) returns 1. Write 1 to CTRL → bus_irq=0. Same-cycle core_done and clear → bus_irq stays 1.
- Out of range (ADDR_W=14): read 0x10000 returns OOR_RDATA and is acknowledged. A write there leaves RAM word 0 unchanged.
- Robustness: a second bus_bus_enable at T+1 produces exactly one acknowledge. Reset asserted at T+1 produces no acknowledge and all outputs return to 0.
